// File: rtl/ssp_xfer_ctrl.sv
// ssp_xfer_ctrl: APB master that configures an SSP (PL022-style) peripheral
// and moves single 16-bit words through it with status polling.
//
// Handshakes: a word moves on any rising PCLK edge where valid and ready
// are both high; valid, once raised, holds with stable data until that edge.
// tx_ready is high only in READY; rx_valid is high only in RX_HOLD, where
// rx_ready is combinationally accepted in the same cycle.
module ssp_xfer_ctrl #(
  parameter int POLL_LIMIT = 1023
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [15:0] cfg_cr0,
  input  logic [7:0]  cfg_cpsr,
  input  logic [3:0]  cfg_cr1,
  input  logic        cfg_start,
  output logic        cfg_done,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [15:0] tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] rx_data,
  output logic        busy,
  output logic        err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [9:0]  PADDR,
  output logic [15:0] PWDATA,
  input  logic [15:0] PRDATA,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CFG      = 4'd1;
  localparam logic [3:0] S_READY    = 4'd2;
  localparam logic [3:0] S_POLL_TNF = 4'd3;
  localparam logic [3:0] S_WR_DR    = 4'd4;
  localparam logic [3:0] S_POLL_RNE = 4'd5;
  localparam logic [3:0] S_RD_DR    = 4'd6;
  localparam logic [3:0] S_RX_HOLD  = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  // SSP register word addresses (byte address >> 2)
  localparam logic [9:0] A_CR0  = 10'h000;
  localparam logic [9:0] A_CR1  = 10'h001;
  localparam logic [9:0] A_DR   = 10'h002;
  localparam logic [9:0] A_SR   = 10'h003;
  localparam logic [9:0] A_CPSR = 10'h004;

  // Counter only needs to reach POLL_LIMIT-1 (index of the last allowed read)
  localparam int CW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_LIMIT - 1);

  logic [3:0]    state;
  logic          acc;        // 0: SETUP phase, 1: ACCESS phase
  logic [1:0]    step;       // which of the four CFG writes
  logic [CW-1:0] poll_cnt;
  logic [15:0]   tx_word;
  logic [15:0]   cr0_q;
  logic [6:0]    cpsr_q;     // CPSR bits [7:1]; bit 0 is forced to 0
  logic [2:0]    cr1_q;      // {SOD, MS, LBM}; SSE is driven by the sequence
  logic          cfg_accept;
  logic          cfg_bad;

  assign cfg_accept = cfg_start &&
                      (state == S_IDLE || state == S_READY || state == S_ERR);
  assign cfg_bad    = (cfg_cpsr[7:1] == 7'd0);

  assign tx_ready  = (state == S_READY) && !cfg_start;
  assign rx_valid  = (state == S_RX_HOLD);
  assign busy      = !(state == S_IDLE || state == S_READY);
  assign dbg_state = state;

  // APB outputs decoded from state/phase; all zero outside an access
  always_comb begin
    PSEL   = 1'b0;
    PWRITE = 1'b0;
    PADDR  = 10'h000;
    PWDATA = 16'h0000;
    case (state)
      S_CFG: begin
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        case (step)
          2'd0:    begin PADDR = A_CR1;  PWDATA = 16'h0000; end
          2'd1:    begin PADDR = A_CR0;  PWDATA = cr0_q; end
          2'd2:    begin PADDR = A_CPSR; PWDATA = {8'h00, cpsr_q, 1'b0}; end
          default: begin PADDR = A_CR1;  PWDATA = {12'h000, cr1_q[2:1], 1'b1, cr1_q[0]}; end
        endcase
      end
      S_POLL_TNF, S_POLL_RNE: begin
        PSEL  = 1'b1;
        PADDR = A_SR;
      end
      S_WR_DR: begin
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PADDR  = A_DR;
        PWDATA = tx_word;
      end
      S_RD_DR: begin
        PSEL  = 1'b1;
        PADDR = A_DR;
      end
      default: ;
    endcase
  end

  assign PENABLE = PSEL & acc;

  // Sequencer: config, transmit, poll, receive; acc alternates SETUP/ACCESS
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= S_IDLE;
      acc      <= 1'b0;
      step     <= 2'd0;
      poll_cnt <= '0;
      tx_word  <= 16'h0000;
      rx_data  <= 16'h0000;
      cr0_q    <= 16'h0000;
      cpsr_q   <= 7'd0;
      cr1_q    <= 3'd0;
      cfg_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_accept) begin
        acc  <= 1'b0;
        step <= 2'd0;
        if (cfg_bad) begin
          state <= S_ERR;
          err   <= 1'b1;
        end else begin
          state  <= S_CFG;
          err    <= 1'b0;
          cr0_q  <= cfg_cr0;
          cpsr_q <= cfg_cpsr[7:1];
          cr1_q  <= {cfg_cr1[3:2], cfg_cr1[0]};
        end
      end else begin
        case (state)
          S_CFG: begin
            acc <= !acc;
            if (acc) begin
              if (step == 2'd3) begin
                state    <= S_READY;
                cfg_done <= 1'b1;
              end else begin
                step <= step + 2'd1;
              end
            end
          end
          S_READY: begin
            if (tx_valid) begin
              tx_word  <= tx_data;
              poll_cnt <= '0;
              state    <= S_POLL_TNF;
            end
          end
          S_POLL_TNF, S_POLL_RNE: begin
            acc <= !acc;
            if (acc) begin
              if ((state == S_POLL_TNF) ? PRDATA[1] : PRDATA[2]) begin
                state <= (state == S_POLL_TNF) ? S_WR_DR : S_RD_DR;
              end else if (poll_cnt == POLL_LAST) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                poll_cnt <= poll_cnt + CW'(1);
              end
            end
          end
          S_WR_DR: begin
            acc <= !acc;
            if (acc) begin
              poll_cnt <= '0;
              state    <= S_POLL_RNE;
            end
          end
          S_RD_DR: begin
            acc <= !acc;
            if (acc) begin
              rx_data <= PRDATA;
              state   <= S_RX_HOLD;
            end
          end
          S_RX_HOLD: begin
            if (rx_ready) state <= S_READY;
          end
          S_IDLE, S_ERR: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ssp_xfer_ctrl.md
SSP_XFER_CTRL -- requirements
Module: ssp_xfer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter POLL_LIMIT SHALL default to 1023 and set the maximum SSPSR status reads per poll before error.
REQ-003 Port PCLK, input, 1: clock; all state SHALL change on its rising edge.
REQ-004 Port PRESET, input, 1: asynchronous active-high reset.
REQ-005 Port cfg_cr0, input, 16: value written to SSPCR0.
REQ-006 Port cfg_cpsr, input, 8: SSPCPSR prescale.
REQ-007 Port cfg_cr1, input, 4: SSPCR1 value {SOD,MS,SSE,LBM}; SSE is ignored.
REQ-008 Port cfg_start, input, 1: one-cycle configure request.
REQ-009 Port cfg_done, output, 1: one-cycle pulse when configuration completes.
REQ-010 Port tx_valid, input, 1 / tx_ready, output, 1 / tx_data, input, 16: transmit word handshake.
REQ-011 Port rx_valid, output, 1 / rx_ready, input, 1 / rx_data, output, 16: receive word handshake.
REQ-012 Port busy, output, 1: high in every state except IDLE and READY.
REQ-013 Port err, output, 1: sticky error flag.
REQ-014 APB master ports SHALL be PSEL, PENABLE, PWRITE (output, 1), PADDR (output, 10, word address [11:2]), PWDATA (output, 16) and PRDATA (input, 16); there is no PREADY.

Function
REQ-015 The FSM SHALL have the states IDLE, CFG, READY, POLL_TNF, WR_DR, POLL_RNE, RD_DR, RX_HOLD and ERR.
REQ-016 Each APB access SHALL take exactly 2 cycles: SETUP (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1).
REQ-017 PADDR, PWRITE and PWDATA SHALL be stable across both cycles of an access.
REQ-018 Read data SHALL be sampled from PRDATA on the clock edge that ends ACCESS.
REQ-019 Accesses SHALL be back-to-back; when no access follows, PSEL=0, PENABLE=0, PADDR=0 and PWDATA=0.
REQ-020 cfg_start SHALL be accepted only in IDLE, READY or ERR, and ignored in every other state.
REQ-021 On acceptance, cfg_cpsr[7:1]==0 SHALL go directly to ERR with err=1 and no APB access.
REQ-022 Otherwise err SHALL clear and CFG SHALL issue four writes: SSPCR1 (0x001) = 0x0000; SSPCR0 (0x000) = cfg_cr0; SSPCPSR (0x004) = {8'h00, cfg_cpsr[7:1], 1'b0}; SSPCR1 = {12'h000, cfg_cr1[3:2], 1'b1, cfg_cr1[0]}.
REQ-023 cfg_done SHALL pulse for one cycle in the cycle after the final ACCESS, and the FSM SHALL enter READY; CFG therefore lasts 8 cycles.
REQ-024 tx_ready SHALL be 1 only in READY; tx_data SHALL be captured when tx_valid and tx_ready are both high, and the FSM SHALL enter POLL_TNF.
REQ-025 POLL_TNF SHALL read SSPSR (0x003) repeatedly, going to WR_DR when bit1 (TNF) is 1.
REQ-026 WR_DR SHALL write the captured word to SSPDR (0x002), then enter POLL_RNE.
REQ-027 POLL_RNE SHALL read SSPSR repeatedly, going to RD_DR when bit2 (RNE) is 1.
REQ-028 RD_DR SHALL read SSPDR into rx_data and enter RX_HOLD.
REQ-029 In RX_HOLD, rx_valid SHALL be 1 and rx_data SHALL be held stable until rx_valid and rx_ready are both high; the FSM then enters READY in the next cycle.
REQ-030 A poll counter SHALL count status reads; if POLL_LIMIT reads occur without the awaited bit set, the FSM SHALL enter ERR with err=1.
REQ-031 ERR SHALL issue no APB accesses, and its only exit SHALL be an accepted cfg_start.
REQ-032 A read of 0xFFFF from SSPSR SHALL be decoded by bit position only (TNF=1 is valid).
REQ-033 If rx_ready is already high when rx_valid rises, the handshake SHALL complete in that same cycle.

Reset
REQ-034 PRESET=1 SHALL immediately force IDLE and set PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready, rx_valid, rx_data, cfg_done, busy and err to 0, including in the middle of an APB access.
REQ-035 After reset the configured state SHALL be lost, and tx_ready SHALL stay 0 until a new CFG completes.

Verification
REQ-036 The bench SHALL cover: cfg_start with cfg_cr0=0x00C7, cfg_cpsr=0x03, cfg_cr1=0x0 -> writes CR1=0x0000, CR0=0x00C7, CPSR=0x0002, CR1=0x0002; cfg_done exactly 8 cycles after start.
REQ-037 The bench SHALL cover: cfg_cpsr=0x01 -> err=1 within 1 cycle, no PSEL activity, tx_ready=0.
REQ-038 The bench SHALL cover: tx_data=0xA55A with an SSP model where SR=0x0003 then 0x0007 and DR=0x5AA5 -> write 0xA55A to 0x002, rx_data=0x5AA5 with rx_valid held through 3 stalled rx_ready cycles.
REQ-039 The bench SHALL cover: POLL_LIMIT=4 with SR stuck at 0x0000 -> exactly 4 SSPSR reads, then err=1, and no further APB access.
REQ-040 The bench SHALL cover: PRESET asserted during the ACCESS of the SSPCR0 write -> all APB outputs 0 in the same cycle, tx_ready=0 until reconfigured.
REQ-041 The bench SHALL cover: cfg_start asserted in POLL_RNE -> ignored; the transfer completes normally.
